uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Transmit-side byte scheduler between the board's control sources and the UART transmitter's dataIn port.
- It is the counterpart of the feedback receive path.
- It turns game-state, target-machine and operate requests into protocol bytes and presents them one per UART byte slot.
- It runs on the UART clock and changes its output only at byte boundaries marked by the UART's data_ready pulse.

Parameters:
- OP_FIFO_DEPTH, 4: number of operate requests that can be queued (power of 2, at least 2).

Ports:
- clock  in  1  UART clock (16x baud).
- reset  in  1  synchronous, active-high.
- game_state_sw  in  1  level; 1 = start requested, 0 = stop requested.
- target_sel  in  6  level; target machine id.
- op_req  in  5  one-cycle pulse, one-hot operate code: [0]=get, [1]=put, [2]=interact, [3]=move, [4]=throw.
- data_ready  in  1  one-cycle pulse from UART; the byte on data_send has finished transmitting.
- data_send  out  8  byte to UART (io_dataIn_bits); 8'h00 = null/idle.
- busy  out  1  1 while data_send != 8'h00.
- op_dropped  out  1  one-cycle pulse when an op_req is discarded.
- fifo_level  out  3  number of queued operate requests (0..OP_FIFO_DEPTH).

Behaviour:
Byte encodings:
- start = 8'h05, stop = 8'h09.
- target = {target_sel, 2'b11}.
- operate = {3'b000, op, 2'b10}.

Reset:
- data_send=8'h00, busy=0, op_dropped=0, fifo_level=0.
- FIFO empty, last_state=0, last_target=6'd0, state=IDLE.

Pending conditions, evaluated every cycle:
- state_pend = (game_state_sw != last_state).
- target_pend = (target_sel != last_target).
- op_pend = FIFO non-empty.

Slot rule:
- data_send changes only on the clock edge that samples data_ready=1.
- In that cycle the next byte is selected with fixed priority state_pend > target_pend > op_pend. If nothing is pending, the next byte is 8'h00.
- When a byte is selected, last_state, last_target or the FIFO head is updated (popped) on the same edge.
- Because the last_* registers are updated at selection, an input that toggles and returns before selection produces no byte.

FSM:
- IDLE: data_send=00. On data_ready with any pending request → LOAD byte → SEND. Otherwise stay in IDLE.
- SEND: byte held. On data_ready, load the next byte if one is pending (stay in SEND); otherwise drive 00 → IDLE.
- The FSM never skips a slot and never alters data_send without data_ready.

Operate acceptance:
- op_req is accepted only if it is exactly one-hot and the effective game state is start.
- The effective game state is last_state, or the stop/start byte being loaded on this edge.
- A non-one-hot, nonzero op_req is dropped with op_dropped=1. A zero op_req is no request.
- An op_req while the game is stopped is dropped, op_dropped=1.
- An op_req with the FIFO full is dropped, op_dropped=1.
- Simultaneous push and pop while full: the pop frees a slot and the push is accepted; fifo_level is unchanged.
- Loading a stop byte flushes the FIFO on the same edge (fifo_level→0). An op_req arriving on that edge is dropped.
- op_dropped is asserted the cycle after the offending op_req and lasts 1 cycle.

Ordering:
- FIFO order is preserved.
- A target change pending when an op is queued is always sent before that op.

Reset mid-operation:
- Reset returns the block to reset values in the same edge.
- The next data_ready after reset starts a fresh schedule. Any byte in flight in the UART is not repeated.

Widths:
- FIFO pointers are log2(OP_FIFO_DEPTH)+1 bits and wrap modulo 2*DEPTH.
- fifo_level is the pointer difference.

Test Plan:
1. After reset, set game_state_sw=1 and pulse data_ready every 160 cycles → data_send 00→05 after the 1st pulse, back to 00 after the 2nd; busy mirrors this.
2. With the game started, set target_sel=6'd7 and the same cycle pulse op_req=5'b00100 → slots carry 8'h1F then 8'h12 then 00; fifo_level goes 1→0 on the second slot.
3. Game started, no data_ready, pulse op_req=5'b00001 five times (DEPTH=4) → fifo_level=4, one op_dropped pulse. Four later data_ready pulses yield 06,06,06,06.
4. op_req=5'b00011 (not one-hot) → op_dropped pulse, fifo_level unchanged. op_req while game_state_sw=0 and last_state=0 → dropped.
5. FIFO holds 2 ops, then set game_state_sw=0 → the next slot carries 09, the FIFO is flushed, and the following slot is 00. An op_req on the flush edge is dropped.
6. Toggle target_sel 3→5→3 between two data_ready pulses → no target byte is sent. Assert reset while in SEND → data_send=00 the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Transmit byte scheduler: turns game-state, target and operate requests into
// protocol bytes, one per UART byte slot delimited by the data_ready pulse.
module uart_tx_scheduler #(
    parameter int OP_FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       game_state_sw,
    input  logic [5:0] target_sel,
    input  logic [4:0] op_req,
    input  logic       data_ready,
    output logic [7:0] data_send,
    output logic       busy,
    output logic       op_dropped,
    output logic [2:0] fifo_level
);

    localparam int AW = $clog2(OP_FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        r_state;
    logic [4:0]    r_fifo [OP_FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_last_state;
    logic [5:0]    r_last_target;
    logic [7:0]    r_data_send;
    logic          r_busy;
    logic          r_op_dropped;

    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_state_pend;
    logic          w_target_pend;
    logic          w_op_pend;
    logic          w_any_pend;
    logic          w_sel_state;
    logic          w_sel_target;
    logic          w_sel_op;
    logic          w_eff_state;
    logic          w_flush;
    logic          w_onehot;
    logic          w_push;
    logic          w_drop;
    logic [4:0]    w_head;
    logic [7:0]    w_next_byte;

    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign w_full        = (w_count == PW'(OP_FIFO_DEPTH));
    assign w_head        = r_fifo[r_rd_ptr[AW-1:0]];

    assign w_state_pend  = (game_state_sw != r_last_state);
    assign w_target_pend = (target_sel != r_last_target);
    assign w_op_pend     = (w_count != '0);
    assign w_any_pend    = w_state_pend | w_target_pend | w_op_pend;

    // Fixed priority: game state, then target, then queued operate.
    assign w_sel_state   = data_ready & w_state_pend;
    assign w_sel_target  = data_ready & ~w_state_pend & w_target_pend;
    assign w_sel_op      = data_ready & ~w_state_pend & ~w_target_pend & w_op_pend;

    // A start/stop byte loaded on this edge already governs op acceptance.
    assign w_eff_state   = w_sel_state ? game_state_sw : r_last_state;
    assign w_flush       = w_sel_state & ~game_state_sw;

    assign w_onehot      = (op_req != 5'd0) && ((op_req & (op_req - 5'd1)) == 5'd0);
    assign w_push        = w_onehot & w_eff_state & (~w_full | w_sel_op);
    assign w_drop        = (op_req != 5'd0) & ~w_push;

    always_comb begin
        w_next_byte = 8'h00;
        if (w_sel_state)
            w_next_byte = game_state_sw ? 8'h05 : 8'h09;
        else if (w_sel_target)
            w_next_byte = {target_sel, 2'b11};
        else if (w_sel_op)
            w_next_byte = {3'b000, w_head, 2'b10};
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_fifo[r_wr_ptr[AW-1:0]] <= op_req;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_last_state  <= 1'b0;
            r_last_target <= 6'd0;
            r_data_send   <= 8'h00;
            r_busy        <= 1'b0;
            r_op_dropped  <= 1'b0;
        end else begin
            r_op_dropped <= w_drop;
            if (data_ready) begin
                r_data_send <= w_next_byte;
                r_busy      <= (w_next_byte != 8'h00);
                case (r_state)
                    IDLE:    if (w_any_pend)  r_state <= SEND;
                    SEND:    if (!w_any_pend) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
            if (w_sel_state)
                r_last_state <= game_state_sw;
            if (w_sel_target)
                r_last_target <= target_sel;
            if (w_flush)
                r_rd_ptr <= r_wr_ptr;
            else if (w_sel_op)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
        end
    end

    assign data_send  = r_data_send;
    assign busy       = r_busy;
    assign op_dropped = r_op_dropped;
    assign fifo_level = 3'(w_count);

endmodule
